retire_recovery_ctrl: RTL and testbench

Branch-mispredict recovery sequencer that sits behind retire. It takes the single-cycle mispredict pulse produced at commit and runs a fixed sequence: flush the pipeline, drain in-flight execution, and copy the architectural map table into the speculative map table N entries per cycle. It then hands the corrected PC to fetch with a valid/ready handshake. It holds dispatch stalled for the whole sequence.

---
 rtl/retire_recovery_ctrl_pkg.sv | 12 +
 rtl/retire_recovery_ctrl.sv | 98 +++++++++
 tb/tb_retire_recovery_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/retire_recovery_ctrl_pkg.sv
// retire_recovery_ctrl_pkg: recovery FSM states, counter sizing helper and system widths.
// The width constants stand in for the sys_defs values used elsewhere in the core.
package retire_recovery_ctrl_pkg;
  localparam int ADDR_W = 32;
  localparam int COMMIT_N = 2;
  localparam int ARCH_REG_SZ = 32;
  localparam int PHYS_REG_SZ_R10K = 64;
  typedef enum logic [2:0] {IDLE, FLUSH, DRAIN, RESTORE, REDIRECT} recov_state_e;
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/retire_recovery_ctrl.sv
// retire_recovery_ctrl: mispredict recovery sequencer (flush, drain, arch->spec map copy, redirect).
module retire_recovery_ctrl
  import retire_recovery_ctrl_pkg::*;
#(
  parameter int N = COMMIT_N,
  parameter int ARCH_COUNT = ARCH_REG_SZ,
  parameter int PHYS_REGS = PHYS_REG_SZ_R10K,
  parameter int DRAIN_CYCLES = 2,
  localparam int REG_W = cnt_w(ARCH_COUNT),
  localparam int TAG_W = cnt_w(PHYS_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mispredict_i,
  input  logic [ADDR_W-1:0]   mispred_target_i,
  input  logic                fu_busy_i,
  output logic [N*REG_W-1:0]  arch_rd_addrs_o,
  input  logic [N*TAG_W-1:0]  arch_rd_tags_i,
  output logic [N-1:0]        spec_wr_en_o,
  output logic [N*REG_W-1:0]  spec_wr_addrs_o,
  output logic [N*TAG_W-1:0]  spec_wr_tags_o,
  output logic                flush_o,
  output logic                stall_o,
  output logic                redirect_valid_o,
  output logic [ADDR_W-1:0]   redirect_pc_o,
  input  logic                redirect_ready_i,
  output logic                recover_busy_o,
  output logic [15:0]         recover_count_o
);
  localparam int BEATS = (ARCH_COUNT + N - 1) / N;
  localparam int BEAT_W = cnt_w(BEATS);
  localparam int DRAIN_W = cnt_w(DRAIN_CYCLES);
  recov_state_e state_q, state_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [15:0] count_q, count_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      target_q <= '0;
      drain_q <= '0;
      beat_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      target_q <= target_d;
      drain_q <= drain_d;
      beat_q <= beat_d;
      count_q <= count_d;
    end
  end
  always_comb begin
    state_d = state_q;
    target_d = target_q;
    drain_d = drain_q;
    beat_d = beat_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (mispredict_i) begin
        state_d = FLUSH;
        target_d = mispred_target_i;
        count_d = count_q + 16'(count_q != 16'hFFFF);
      end
      FLUSH: begin
        state_d = DRAIN;
        drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
      end
      // the minimum drain time counts down even while FUs are still busy
      DRAIN: if (drain_q == '0 && !fu_busy_i) begin
        state_d = RESTORE;
        beat_d = '0;
      end else if (drain_q != '0) begin
        drain_d = drain_q - DRAIN_W'(1);
      end
      RESTORE: if (beat_q == BEAT_W'(BEATS - 1)) state_d = REDIRECT;
               else beat_d = beat_q + BEAT_W'(1);
      REDIRECT: if (redirect_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign recover_busy_o = state_q != IDLE;
  assign stall_o = recover_busy_o;
  assign flush_o = state_q == FLUSH;
  assign redirect_valid_o = state_q == REDIRECT;
  assign redirect_pc_o = redirect_valid_o ? target_q : '0;
  assign recover_count_o = count_q;
  for (genvar w = 0; w < N; w++) begin : g_lane
    logic [31:0] idx;
    logic hit;
    assign idx = 32'(beat_q) * N + w;
    assign hit = state_q == RESTORE && idx < ARCH_COUNT;
    assign arch_rd_addrs_o[w*REG_W +: REG_W] = hit ? REG_W'(idx) : '0;
    assign spec_wr_addrs_o[w*REG_W +: REG_W] = hit ? REG_W'(idx) : '0;
    assign spec_wr_en_o[w] = hit;
    assign spec_wr_tags_o[w*TAG_W +: TAG_W] = hit ? arch_rd_tags_i[w*TAG_W +: TAG_W] : '0;
  end
endmodule

// File: tb/tb_retire_recovery_ctrl.sv
// tb_retire_recovery_ctrl: scoreboarded bench for the recovery sequencer (N=2 and N=3 instances).
module tb_retire_recovery_ctrl;
  logic clk = 0, rst_n = 0;
  int cyc = 0, tests = 0, fails = 0, exp_cnt = 0, t1 = 0, flush_seen = 0;
  logic [5:0] arch_map [32];
  logic mp = 0, busy = 0, rdy = 0;
  logic [31:0] tgt = '0;
  logic [9:0] a_addr, w_addr;
  logic [11:0] a_tag, w_tag;
  logic [1:0] en;
  logic flush, stall, rv, rbusy;
  logic [31:0] rpc;
  logic [15:0] rcnt;
  logic mp3 = 0, rdy3 = 0;
  logic [31:0] tgt3 = '0;
  logic [14:0] a3_addr, w3_addr;
  logic [17:0] a3_tag, w3_tag;
  logic [2:0] en3;
  logic flush3, stall3, rv3, rbusy3;
  logic [31:0] rpc3;
  logic [15:0] rcnt3;
  typedef struct { int e_cyc; logic [1:0] e_en; logic [9:0] e_addrs; } beat_t;
  beat_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  retire_recovery_ctrl #(.N(2), .ARCH_COUNT(32), .PHYS_REGS(64), .DRAIN_CYCLES(2)) d2 (
    .clk(clk), .rst_n(rst_n), .mispredict_i(mp), .mispred_target_i(tgt), .fu_busy_i(busy),
    .arch_rd_addrs_o(a_addr), .arch_rd_tags_i(a_tag), .spec_wr_en_o(en),
    .spec_wr_addrs_o(w_addr), .spec_wr_tags_o(w_tag), .flush_o(flush), .stall_o(stall),
    .redirect_valid_o(rv), .redirect_pc_o(rpc), .redirect_ready_i(rdy),
    .recover_busy_o(rbusy), .recover_count_o(rcnt));

  retire_recovery_ctrl #(.N(3), .ARCH_COUNT(32), .PHYS_REGS(64), .DRAIN_CYCLES(2)) d3 (
    .clk(clk), .rst_n(rst_n), .mispredict_i(mp3), .mispred_target_i(tgt3), .fu_busy_i(1'b0),
    .arch_rd_addrs_o(a3_addr), .arch_rd_tags_i(a3_tag), .spec_wr_en_o(en3),
    .spec_wr_addrs_o(w3_addr), .spec_wr_tags_o(w3_tag), .flush_o(flush3), .stall_o(stall3),
    .redirect_valid_o(rv3), .redirect_pc_o(rpc3), .redirect_ready_i(rdy3),
    .recover_busy_o(rbusy3), .recover_count_o(rcnt3));

  always_comb begin
    for (int w = 0; w < 2; w++) a_tag[w*6 +: 6] = arch_map[a_addr[w*5 +: 5]];
    for (int w = 0; w < 3; w++) a3_tag[w*6 +: 6] = arch_map[a3_addr[w*5 +: 5]];
  end

  // scoreboard consumer: every spec-map write beat must match the next expected beat
  always @(negedge clk) begin
    if (flush) flush_seen++;
    if (rst_n && en !== 2'b00) begin
      beat_t e;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_write: cyc=%0d en=%b addrs=%h, expected no write", cyc, en, w_addr);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.e_cyc || en !== e.e_en || w_addr !== e.e_addrs ||
            w_tag !== {arch_map[e.e_addrs[9:5]], arch_map[e.e_addrs[4:0]]}) begin
          fails++;
          $display("FAIL sb_write_beat: cyc=%0d en=%b addrs=%h tags=%h, expected cyc=%0d en=%b addrs=%h tags=%h",
                   cyc, en, w_addr, w_tag, e.e_cyc, e.e_en, e.e_addrs,
                   {arch_map[e.e_addrs[9:5]], arch_map[e.e_addrs[4:0]]});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_map();
    for (int i = 0; i < 32; i++) arch_map[i] = 6'($urandom);
  endtask

  task automatic mispredict(input logic [31:0] pc, input int d);
    mp = 1;
    tgt = pc;
    tick();
    mp = 0;
    tgt = '0;
    exp_cnt++;
    t1 = cyc;
    for (int k = 0; k < 16; k++)
      sb.push_back('{e_cyc: t1 + 1 + d + k, e_en: 2'b11, e_addrs: {5'(2*k+1), 5'(2*k)}});
  endtask

  task automatic wait_redirect(input int exp_cyc, input logic [31:0] exp_pc);
    for (int i = 0; i < 200 && !rv; i++) tick();
    tests++;
    if (rv !== 1'b1 || cyc !== exp_cyc || rpc !== exp_pc || stall !== 1'b1) begin
      fails++;
      $display("FAIL redirect_arrival: valid=%b cyc=%0d pc=%h stall=%b, expected valid=1 cyc=%0d pc=%h stall=1",
               rv, cyc, rpc, stall, exp_cyc, exp_pc);
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL restore_beats_missing: %0d beats left, expected 0", sb.size());
    end
  endtask

  task automatic accept();
    rdy = 1;
    tick();
    rdy = 0;
    tests++;
    if ({rbusy, stall, rv, flush} !== 4'b0000 || rcnt !== 16'(exp_cnt)) begin
      fails++;
      $display("FAIL accept_idle: busy/stall/valid/flush=%b count=%0d, expected 0000 count=%0d",
               {rbusy, stall, rv, flush}, rcnt, exp_cnt);
    end
  endtask

  task automatic check_all_zero(input string name);
    tests++;
    if ({flush, stall, rv, rbusy, en, flush3, stall3, rv3, rbusy3, en3} !== '0 ||
        {a_addr, w_addr, w_tag, a3_addr, w3_addr, w3_tag, rpc, rpc3, rcnt, rcnt3} !== '0) begin
      fails++;
      $display("FAIL %s: ctl=%b addr/tag/pc/count nonzero=%b, expected all 0", name,
               {flush, stall, rv, rbusy, en, flush3, stall3, rv3, rbusy3, en3},
               |{a_addr, w_addr, w_tag, a3_addr, w3_addr, w3_tag, rpc, rpc3, rcnt, rcnt3});
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    check_all_zero("reset_outputs");
    rst_n = 1;
    tick();
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_nominal();
    mispredict(32'h100, 2);
    tests++;
    if (flush !== 1'b1 || stall !== 1'b1 || rbusy !== 1'b1) begin
      fails++;
      $display("FAIL flush_pulse: flush=%b stall=%b busy=%b, expected 1 1 1", flush, stall, rbusy);
    end
    tick();
    tests++;
    if (flush !== 1'b0 || stall !== 1'b1) begin
      fails++;
      $display("FAIL flush_single: flush=%b stall=%b, expected 0 1", flush, stall);
    end
    wait_redirect(t1 + 19, 32'h100);
    accept();
  endtask

  task automatic test_drain_extension();
    fill_map();
    mispredict(32'h180, 6);
    busy = 1;
    repeat (6) tick();
    busy = 0;
    wait_redirect(t1 + 23, 32'h180);
    accept();
  endtask

  task automatic test_backpressure();
    mispredict(32'h240, 2);
    wait_redirect(t1 + 19, 32'h240);
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (rv !== 1'b1 || rpc !== 32'h240 || stall !== 1'b1) begin
        fails++;
        $display("FAIL backpressure_hold: valid=%b pc=%h stall=%b, expected 1 00000240 1", rv, rpc, stall);
      end
    end
    accept();
  endtask

  task automatic test_ignored_mispredict();
    int f0;
    f0 = flush_seen;
    mispredict(32'h100, 2);
    tick();
    mp = 1;
    tgt = 32'h200;
    tick();
    mp = 0;
    tgt = '0;
    wait_redirect(t1 + 19, 32'h100);
    tests++;
    if (flush_seen - f0 !== 1 || rcnt !== 16'(exp_cnt)) begin
      fails++;
      $display("FAIL ignored_mispredict: flushes=%0d count=%0d, expected 1 %0d", flush_seen - f0, rcnt, exp_cnt);
    end
    accept();
  endtask

  task automatic test_partial_beat();
    int beats;
    logic [2:0] last_en, exp_en;
    logic [14:0] last_addr;
    beats = 0;
    last_en = '0;
    last_addr = '0;
    mp3 = 1;
    tgt3 = 32'h400;
    tick();
    mp3 = 0;
    for (int i = 0; i < 80 && !rv3; i++) begin
      if (en3 !== 3'b000) begin
        logic bad;
        bad = 0;
        for (int w = 0; w < 3; w++) begin
          exp_en[w] = (beats * 3 + w) < 32;
          if (exp_en[w] && (w3_addr[w*5 +: 5] !== 5'(beats*3+w) || w3_tag[w*6 +: 6] !== arch_map[beats*3+w]))
            bad = 1;
        end
        tests++;
        if (bad || en3 !== exp_en) begin
          fails++;
          $display("FAIL n3_beat%0d: en=%b addrs=%h tags=%h, expected en=%b base addr %0d",
                   beats, en3, w3_addr, w3_tag, exp_en, beats * 3);
        end
        last_en = en3;
        last_addr = w3_addr;
        beats++;
      end
      tick();
    end
    tests++;
    if (beats !== 11 || last_en !== 3'b011 || last_addr[9:0] !== {5'd31, 5'd30} ||
        rv3 !== 1'b1 || rpc3 !== 32'h400) begin
      fails++;
      $display("FAIL n3_last_beat: beats=%0d en=%b addrs=%h valid=%b pc=%h, expected 11 011 (31,30) 1 00000400",
               beats, last_en, last_addr[9:0], rv3, rpc3);
    end
    rdy3 = 1;
    tick();
    rdy3 = 0;
    tests++;
    if (rbusy3 !== 1'b0 || stall3 !== 1'b0 || rcnt3 !== 16'd1) begin
      fails++;
      $display("FAIL n3_accept: busy=%b stall=%b count=%0d, expected 0 0 1", rbusy3, stall3, rcnt3);
    end
  endtask

  task automatic test_async_reset();
    mispredict(32'h300, 2);
    repeat (6) tick();
    tests++;
    if (en !== 2'b11) begin
      fails++;
      $display("FAIL mid_restore_reached: en=%b, expected 11", en);
    end
    #2 rst_n = 0;
    #1 check_all_zero("async_reset_mid_restore");
    sb.delete();
    exp_cnt = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
    check_all_zero("idle_after_second_reset");
    test_nominal();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    fill_map();
    test_reset();
    test_nominal();
    test_drain_extension();
    test_backpressure();
    test_ignored_mispredict();
    test_partial_beat();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
